// File: rtl/mem_access_unit_if.sv
// Bundle of the CPU request/response channel and the word-organised memory port.
// The unit sits on the slave side; the core and memory models use the master side.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-3:0] mem_waddr;
    logic [ADDR_WIDTH-3:0] mem_raddr;
    logic                  mem_wren;
    logic                  mem_rden;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_waddr, mem_raddr, mem_wren, mem_rden, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_waddr, mem_raddr, mem_wren, mem_rden, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store initiator: sub-word stores are done as read-modify-write,
// loads are lane-extracted and sign/zero extended, misaligned or illegal sizes report an error.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 11
) (
    input logic               clk,
    input logic               resetn,
    mem_access_unit_if.slave  bus
);
    localparam int WAW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [WAW-1:0]  waddr_q, waddr_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     merge_q, merge_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            reqErr;
    logic [7:0]      byteVal;
    logic [15:0]     halfVal;
    logic [31:0]     loadVal;
    logic [31:0]     mergeVal;

    // Little-endian lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        byteVal  = bus.mem_rdata[{lane_q, 3'b000} +: 8];
        halfVal  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        loadVal  = bus.mem_rdata;
        mergeVal = bus.mem_rdata;
        case (size_q)
            2'd0: loadVal = uns_q ? {24'b0, byteVal} : {{24{byteVal[7]}}, byteVal};
            2'd1: loadVal = uns_q ? {16'b0, halfVal} : {{16{halfVal[15]}}, halfVal};
            default: loadVal = bus.mem_rdata;
        endcase
        if (size_q == 2'd0) begin
            mergeVal[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (lane_q[1]) begin
            mergeVal[31:16] = wdata_q[15:0];
        end else begin
            mergeVal[15:0] = wdata_q[15:0];
        end
    end

    assign reqErr = (bus.req_size == 2'd3) ||
                    (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                    (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        waddr_d = waddr_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    waddr_d = bus.req_addr[ADDR_WIDTH-1:2];
                    lane_d  = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata;
                    if (reqErr) begin
                        rdata_d = 32'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (bus.req_we && bus.req_size == 2'd2) begin
                        merge_d = bus.req_wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    merge_d = mergeVal;
                    state_d = WRITE;
                end else begin
                    rdata_d = loadVal;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            WRITE: begin
                rdata_d = 32'b0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are pure state decodes so the async reset drops them immediately.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.mem_rden   = (state_q == READ);
    assign bus.mem_wren   = (state_q == WRITE);
    assign bus.mem_raddr  = waddr_q;
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_wdata  = merge_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            waddr_q <= '0;
            lane_q  <= 2'd0;
            wdata_q <= 32'b0;
            merge_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            waddr_q <= waddr_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the CPU core's memory stage and the word-organised data memory port: write on a clock edge, read asynchronous, separate `Waddr`/`Raddr`, `Wren`/`Rden` strobes. It accepts one byte, halfword or word load/store at a time over a valid/ready request channel. Sub-word stores become a read-modify-write sequence, and loads are lane-extracted with sign or zero extension. A one-cycle response pulse returns the load data or a misalignment error.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: byte-address width of the memory; word address is `ADDR_WIDTH-2` bits.

Ports:
- `clk` in 1: clock; every register samples on its rising edge.
- `resetn` in 1: reset; one clock; asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request (high only in IDLE).
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = halfword, 2 = word; 3 is illegal and reported as an error.
- `req_unsigned` in 1: zero-extend a load (lbu/lhu).
- `req_addr` in 32: byte address; bits above `ADDR_WIDTH-1` are ignored.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access or illegal size; qualified by `resp_valid`.
- `mem_waddr` out `ADDR_WIDTH-2`: memory write word address.
- `mem_raddr` out `ADDR_WIDTH-2`: memory read word address.
- `mem_wren` out 1: memory write enable.
- `mem_rden` out 1: memory read enable.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data; combinational from `mem_raddr`/`mem_rden`.

## Operation
- States: IDLE, READ, WRITE, RESP. Encoding is free.
- IDLE:
  - `req_ready`=1. On `req_valid`, capture `req_we`, `req_size`, `req_unsigned`, word address `req_addr[ADDR_WIDTH-1:2]`, lane `req_addr[1:0]` and `req_wdata`.
  - Error check: misaligned is a halfword with lane bit 0 set, or a word with a nonzero lane; `req_size`=3 is also an error. An error goes to RESP with err=1, with no memory strobe at any point.
  - Otherwise, a load or a sub-word store goes to READ, and a word store goes to WRITE with merge = `req_wdata`.
- READ:
  - `mem_rden`=1 and `mem_raddr`=captured word address.
  - A load registers the extracted value into `resp_rdata` and goes to RESP.
  - A sub-word store registers a merge word and goes to WRITE. The merge word is `mem_rdata` with the selected byte/halfword lane replaced by the low 8/16 bits of the captured wdata.
- WRITE: `mem_wren`=1, `mem_waddr`=captured word address, `mem_wdata`=merge register. Goes to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Endianness is little: byte lane k is bits `[8k+7:8k]`, and halfword lane 2 is bits `[31:16]`.
- Load extraction: byte/half is right-aligned, then sign-extended from bit 7/15, or zero-extended if `req_unsigned`. Word loads pass through unchanged.
- `mem_rden` and `mem_wren` are decoded from the state only, so they are never high together and never high outside READ/WRITE.
- `mem_raddr`/`mem_waddr` come from the captured address register; `mem_wdata` comes from the merge register. Values outside the strobe states are don't-care.
- `resp_rdata`/`resp_err` hold their value until the next response; stores and errors write 0 into `resp_rdata`.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_wren`=0, `mem_rden`=0, captured and merge registers 0.
- Request accepted at edge N (IDLE, `req_valid`=1). Response pulse timing:
  - load: pulse in cycle N+2;
  - word store: memory written at edge N+2, pulse in cycle N+2;
  - sub-word store: read in N+1, written at edge N+3, pulse in N+3;
  - error: pulse in N+1.
- Requests are not accepted while busy: `req_ready`=0 from cycle N+1 until the cycle after the pulse. If `req_valid` is held, the next acceptance occurs in the cycle after RESP.
- Reset asserted mid-operation: immediate return to IDLE, and the strobes drop asynchronously. A WRITE interrupted before its edge does not write, and no `resp_valid` is produced for the aborted request.
- The memory read path is combinational, so `mem_rdata` is sampled in the same cycle `mem_rden` is high.

## Test plan
- Word store 0x11223344 to 0x40, then word load from 0x40 -> memory word 0x10 = 0x11223344; load `resp_rdata`=0x11223344 at N+2; store pulse at N+2 with no READ cycle.
- Byte store 0xAB to 0x41 over 0x11223344 -> exactly one `mem_rden` cycle then one `mem_wren` cycle; word becomes 0x1122AB44; pulse at N+3.
- Word 0x8000_7F80 at 0x48, then byte loads from 0x48 and 0x49 and halfword load from 0x4A, each signed and unsigned:
  - lb 0x48 -> 0xFFFFFF80, lbu 0x48 -> 0x00000080;
  - lb 0x49 -> 0x0000007F;
  - lh 0x4A -> 0xFFFF8000, lhu 0x4A -> 0x00008000.
- Halfword store to 0x43, word load from 0x42, and `req_size`=3 -> each gives `resp_err`=1 with `resp_valid` at N+1, `mem_wren`/`mem_rden` never high, and `resp_rdata`=0.
- `resetn` pulsed low during WRITE of a byte store -> `mem_wren` falls immediately; memory word unchanged; no `resp_valid`; `req_ready`=1 after release.
- `req_valid` held high for three back-to-back word loads -> acceptances spaced 3 cycles apart, three single-cycle pulses with correct data.
